d_flip_flop: RTL and testbench
==============================

Name: d_flip_flop

Overview:
- Positive-edge-triggered D flip-flop with asynchronous active-high reset.
- Basic storage element for the gate-built CPU: registers, program counter and pipeline latches are assembled from it.
- Implemented structurally as a master-slave pair of gated D latches built from 2-input NAND/NOR gates and an inverter, replicated per bit.
- Behavioural `always @(posedge clk)` storage is not permitted.

Parameters:
- WIDTH, 1, number of independent bits stored; each bit has its own master and slave latch, and all bits share clk and rst.

Ports:
- clk  input  1  single clock; data is captured on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears the stored value to 0.
- D  input  WIDTH  data to be captured.
- Q  output  WIDTH  stored value.

Behaviour:
- Edge capture
  - On each 0->1 transition of clk with rst low, Q takes the value D held just before the edge.
  - Q then holds that value until the next rising edge.
  - Latency is one edge: a D change made mid-cycle appears on Q at the next rising edge, never before.
- Master-slave structure
  - Master latch is transparent while clk=0 and holds while clk=1.
  - Slave latch is transparent while clk=1 and copies the master.
  - Consequence: D changes while clk=1 do not reach Q.
  - Consequence: D changes while clk=0 do not reach Q until the rising edge.
- Falling edge: no change to Q.
- Reset
  - rst=1 forces Q=0 and clears the master latch immediately, without waiting for a clock edge.
  - Reset is asynchronous and must be implemented inside the latch gates, not as a gate on D.
  - While rst=1, clk and D are ignored.
- Reset release
  - After rst falls, Q stays 0 until the next rising clk edge with rst low.
  - At that edge, normal capture resumes.
- Reset value: Q=0 on all bits.
- Simultaneous rst rise and clk edge: reset wins, Q=0.
- Simultaneous rst fall and clk rise: the capture on that edge is not guaranteed. The environment must not rely on it; capture is guaranteed from the following edge.
- Power-up without reset: Q is unknown (X in simulation) until the first rising edge or the first reset pulse. A design must pulse rst before relying on Q.
- Per-bit independence: bit i of Q depends only on bit i of D.
- Timing: zero-delay gates are acceptable. Simulation must not oscillate or produce X after reset with legal (non-simultaneous) stimulus.

Test Plan:
- Reset: rst=1 at t=0 with D=1 and clk toggling (10 ns period, first rising edge at 5 ns). Required: Q=0 throughout, and Q stays 0 until the first rising edge after rst falls.
- Basic capture (WIDTH=1)
  - Setup: clk starts at 0 with a 10 ns period, so rising edges occur at 5, 15, 25 ns and so on. rst is pulsed and released before 5 ns, and D=0 initially.
  - Stimulus: set D=1,0,1,0,1,0 at t=7,17,27,37,47,57 ns.
  - Required: Q=0 before 15 ns, then Q=1 at 15 ns, 0 at 25 ns, 1 at 35 ns, 0 at 45 ns, 1 at 55 ns and 0 at 65 ns.
  - Required: Q never changes between rising edges.
- Transparency check
  - Pulse D 0->1->0 entirely within a clk=1 phase. Required: Q unchanged.
  - Pulse D 0->1->0 entirely within a clk=0 phase, returning to 0 before the rising edge. Required: Q stays 0.
- Async reset mid-cycle: with Q=1, assert rst at 3 ns after a rising edge. Required: Q=0 within the same time step, with no clock edge needed. Hold D=1 and release rst. Required: Q=1 at the next rising edge.
- Multi-bit (WIDTH=8)
  - Apply D=8'hA5 and clock once. Required: Q=8'hA5.
  - Then apply D=8'h5A and clock once. Required: Q=8'h5A.
  - Then assert rst. Required: Q=8'h00.
- Falling edge and hold: change D just before a falling edge. Required: Q unchanged until the next rising edge, where it takes the new D.

Source files
------------

// File: rtl/d_flip_flop.sv
// Positive-edge D flip-flop built as a master-slave pair of gated D latches per bit.
// Asynchronous active-high reset clears both latches directly inside the latch cells.
module d_flip_flop #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic clk_n;

    // Shared clock inverter: the master is transparent on the low phase.
    assign clk_n = ~clk;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic d_n;
        logic m_set_n;
        logic m_rst_n;
        logic m_q;
        logic m_q_n;
        logic s_set_n;
        logic s_rst_n;
        logic s_q;

        assign d_n = ~D[i];

        // Master steering NANDs: active-low set/reset pulses only while clk=0.
        assign m_set_n = ~(D[i] & clk_n);
        assign m_rst_n = ~(d_n & clk_n);

        // Cross-coupled NAND pair expressed as a level-sensitive hold so the
        // netlist carries no zero-delay combinational loop; rst overrides both inputs.
        always_latch begin
            if (rst) begin
                m_q <= 1'b0;
            end else if (!m_set_n) begin
                m_q <= 1'b1;
            end else if (!m_rst_n) begin
                m_q <= 1'b0;
            end
        end

        assign m_q_n = ~m_q;

        // Slave steering NANDs: copy the master only while clk=1.
        assign s_set_n = ~(m_q & clk);
        assign s_rst_n = ~(m_q_n & clk);

        always_latch begin
            if (rst) begin
                s_q <= 1'b0;
            end else if (!s_set_n) begin
                s_q <= 1'b1;
            end else if (!s_rst_n) begin
                s_q <= 1'b0;
            end
        end

        assign Q[i] = s_q;
    end

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: a 1-bit and an 8-bit instance share clk/rst,
// expected Q values are queued by the driver and checked by a separate monitor.
`timescale 1ns/1ps
module tb_d_flip_flop;

  logic       clk;
  logic       rst;
  logic       d1;
  logic [7:0] d8;
  logic       q1;
  logic [7:0] q8;

  logic [8:0] exp_q[$];
  string      name_q[$];
  event       chk_ev;
  int         checks;
  int         failures;

  d_flip_flop #(.WIDTH(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .D   (d1),
    .Q   (q1)
  );

  d_flip_flop #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .D   (d8),
    .Q   (q8)
  );

  // clock / reset: rising edges at 5, 15, 25 ns ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic at(input realtime t);
    #(t - $realtime);
  endtask

  task automatic expect_q(input string name, input logic e1, input logic [7:0] e8);
    exp_q.push_back({e1, e8});
    name_q.push_back(name);
    -> chk_ev;
  endtask

  // scoreboard monitor
  initial begin
    logic [8:0] e;
    string      n;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if ({q1, q8} !== e) begin
          failures++;
          $display("FAIL %s at %0t: Q1=%b Q8=%h expected Q1=%b Q8=%h",
                   n, $time, q1, q8, e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    logic       v;
    logic [7:0] v8;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    d1  = 1'b1;
    d8  = 8'hFF;

    // reset held across clock edges with D=1
    at(2);   expect_q("reset_t2", 1'b0, 8'h00);
    at(7);   expect_q("reset_after_edge5", 1'b0, 8'h00);
    at(17);  expect_q("reset_after_edge15", 1'b0, 8'h00);
    at(22);  rst = 1'b0;
    at(24);  expect_q("release_no_edge_yet", 1'b0, 8'h00);
    at(27);  expect_q("first_capture_after_release", 1'b1, 8'hFF);

    // async reset 3 ns after a rising edge, with Q=1
    at(28);  rst = 1'b1;
    #0.001;  expect_q("async_reset_immediate", 1'b0, 8'h00);
    at(32);  rst = 1'b0;
    at(34);  expect_q("async_release_hold", 1'b0, 8'h00);
    at(36);  expect_q("async_recapture", 1'b1, 8'hFF);

    // basic capture: reset pulse in a low phase, D=0
    at(38);  rst = 1'b1; d1 = 1'b0; d8 = 8'h00;
    at(41);  rst = 1'b0;
    at(44);  expect_q("capture_init_zero", 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      v  = (i % 2 == 0);
      v8 = v ? 8'hA5 : 8'h5A;
      at(47.0 + 10.0 * i);
      d1 = v;
      d8 = v8;
      at(48.0 + 10.0 * i);
      if (i == 0) expect_q("capture_no_early", 1'b0, 8'h00);
      else        expect_q("capture_hold_after_d", ~v, v ? 8'h5A : 8'hA5);
      at(53.0 + 10.0 * i);
      if (i == 0) expect_q("capture_no_early_low", 1'b0, 8'h00);
      else        expect_q("capture_hold_low", ~v, v ? 8'h5A : 8'hA5);
      at(56.0 + 10.0 * i);
      expect_q("capture_edge", v, v8);
    end

    // multi-bit reset after capture of 5A
    at(108); rst = 1'b1;
    #0.001;  expect_q("reset_multibit", 1'b0, 8'h00);
    at(112); rst = 1'b0;
    at(114); expect_q("reset_multibit_hold", 1'b0, 8'h00);
    at(116); expect_q("recapture_5a", 1'b0, 8'h5A);

    // D pulse entirely inside a clk=1 phase
    at(116.5); d1 = 1'b1; d8 = 8'hFF;
    at(118);   d1 = 1'b0; d8 = 8'h5A;
    at(119);   expect_q("high_phase_pulse", 1'b0, 8'h5A);
    // D pulse entirely inside a clk=0 phase
    at(121);   d1 = 1'b1; d8 = 8'h00;
    at(123);   d1 = 1'b0; d8 = 8'h5A;
    at(124);   expect_q("low_phase_pulse", 1'b0, 8'h5A);
    at(126);   expect_q("low_phase_pulse_edge", 1'b0, 8'h5A);

    // D changes just before a falling edge
    at(129);   d1 = 1'b1; d8 = 8'h3C;
    at(131);   expect_q("falling_edge_no_change", 1'b0, 8'h5A);
    at(134);   expect_q("falling_edge_hold", 1'b0, 8'h5A);
    at(136);   expect_q("falling_edge_next_rise", 1'b1, 8'h3C);

    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
